// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register with flush, optional 2-entry skid buffer and stall counter.
// Control payload is forced to zero whenever no entry is presented downstream.
module pipe_stage_buf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter bit          SKID   = 1'b1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_ready_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              in_fire, out_fire;

  assign out_valid = (state_q != StEmpty);
  // Gated by rst so the stage refuses input during reset and accepts right after release.
  assign in_ready  = rst & (SKID ? in_ready_q : (~out_valid | out_ready));
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign out_data  = main_data_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    occupancy = 2'd0;
    unique case (state_q)
      StOne:   occupancy = 2'd1;
      StTwo:   occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
            state_d     = StOne;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (in_fire) begin
            // Only reachable with SKID=1: head is stalled, park the newcomer.
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            state_d     = StTwo;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (out_fire) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            state_d     = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StEmpty;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      in_ready_q  <= (state_d != StTwo);
      if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a SKID=1 and a SKID=0/CNT_W=4 instance share stimulus, each checked
// every cycle against a small FIFO model, plus directed literal checks.
module tb_pipe_stage_buf;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [31:0] a_out_data, b_out_data;
  logic [7:0]  a_out_ctrl, b_out_ctrl;
  logic [1:0]  a_occupancy, b_occupancy;
  logic [15:0] a_stall_cnt;
  logic [3:0]  b_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: per instance a FIFO of up to two {data,ctrl} entries, last head data, stall count.
  logic [39:0] m_q [2][2];
  int          m_cnt [2];
  logic [31:0] m_last [2];
  int          m_stall [2];
  int          m_max [2];

  pipe_stage_buf #(.DATA_W(32), .CTRL_W(8), .SKID(1'b1), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_ctrl(a_out_ctrl), .occupancy(a_occupancy),
    .stall_cnt(a_stall_cnt)
  );

  pipe_stage_buf #(.DATA_W(32), .CTRL_W(8), .SKID(1'b0), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_ctrl(b_out_ctrl), .occupancy(b_occupancy),
    .stall_cnt(b_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_ready(input int i);
    if (!rst) return 1'b0;
    if (i == 0) return m_cnt[0] < 2;
    return (m_cnt[1] == 0) || out_ready;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      logic ir, ov, inf, outf;
      if (!rst) begin
        m_cnt[i]   = 0;
        m_last[i]  = '0;
        m_stall[i] = 0;
      end else begin
        ov   = m_cnt[i] > 0;
        ir   = exp_ready(i);
        inf  = in_valid && ir;
        outf = ov && out_ready;
        if (ov && !out_ready && m_stall[i] < m_max[i]) m_stall[i]++;
        if (flush) begin
          m_cnt[i] = 0;
        end else begin
          if (outf) begin
            m_q[i][0] = m_q[i][1];
            m_cnt[i]--;
          end
          if (inf) begin
            m_q[i][m_cnt[i]] = {in_data, in_ctrl};
            m_cnt[i]++;
          end
        end
        if (m_cnt[i] > 0) m_last[i] = m_q[i][0][39:8];
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      logic        ov, av, ar;
      logic [39:0] h;
      logic [31:0] ed, ad;
      logic [7:0]  ec, ac;
      logic [1:0]  ao;
      logic [15:0] as;
      string       p;
      p  = (i == 0) ? "a" : "b";
      ov = m_cnt[i] > 0;
      h  = m_q[i][0];
      ed = ov ? h[39:8] : m_last[i];
      ec = ov ? h[7:0] : 8'h00;
      av = (i == 0) ? a_out_valid : b_out_valid;
      ar = (i == 0) ? a_in_ready : b_in_ready;
      ad = (i == 0) ? a_out_data : b_out_data;
      ac = (i == 0) ? a_out_ctrl : b_out_ctrl;
      ao = (i == 0) ? a_occupancy : b_occupancy;
      as = (i == 0) ? a_stall_cnt : {12'h000, b_stall_cnt};
      cmp({p, ".out_valid"}, 64'(av), 64'(ov));
      cmp({p, ".in_ready"},  64'(ar), 64'(exp_ready(i)));
      cmp({p, ".out_data"},  64'(ad), 64'(ed));
      cmp({p, ".out_ctrl"},  64'(ac), 64'(ec));
      cmp({p, ".occupancy"}, 64'(ao), 64'(m_cnt[i]));
      cmp({p, ".stall_cnt"}, 64'(as), 64'(m_stall[i]));
    end
  endtask

  // Drive inputs, advance one clock (model follows the edge), then check at the falling edge.
  task automatic step(input logic iv, input logic [31:0] d, input logic [7:0] c,
                      input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    m_max[0] = 65535;
    m_max[1] = 15;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]   = 0;
      m_last[i]  = '0;
      m_stall[i] = 0;
      m_q[i][0]  = '0;
      m_q[i][1]  = '0;
    end
    rst = 1'b0;

    // Reset held 3 cycles with a valid, all-ones control input.
    for (int k = 0; k < 3; k++) step(1'b1, 32'hdead_beef, 8'hFF, 1'b0, 1'b0);
    cmp("rst.out_valid", 64'(a_out_valid), 64'd0);
    cmp("rst.out_ctrl",  64'(a_out_ctrl),  64'd0);
    cmp("rst.in_ready",  64'(a_in_ready),  64'd0);
    cmp("rst.occupancy", 64'(a_occupancy), 64'd0);
    cmp("rst.stall_cnt", 64'(a_stall_cnt), 64'd0);
    rst = 1'b1;
    #1;
    cmp("rel.a_in_ready", 64'(a_in_ready), 64'd1);
    cmp("rel.b_in_ready", 64'(b_in_ready), 64'd1);

    // Back-to-back stream with downstream always ready.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 32'h11 + k, 8'(k + 1), 1'b1, 1'b0);
      cmp("stream.data", 64'(a_out_data), 64'(32'h11 + k));
      cmp("stream.occ",  64'(a_occupancy), 64'd1);
      cmp("stream.rdy",  64'(a_in_ready), 64'd1);
    end
    step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
    cmp("stream.stall", 64'(a_stall_cnt), 64'd0);

    // Stalled A,B then C waits; release drains in order.
    step(1'b1, 32'hA0, 8'h5A, 1'b0, 1'b0);
    cmp("skid.occ1", 64'(a_occupancy), 64'd1);
    step(1'b1, 32'hB0, 8'h5B, 1'b0, 1'b0);
    cmp("skid.occ2", 64'(a_occupancy), 64'd2);
    cmp("skid.rdy0", 64'(a_in_ready), 64'd0);
    cmp("skid.holdA", 64'(a_out_data), 64'hA0);
    step(1'b1, 32'hC0, 8'h5C, 1'b0, 1'b0);
    cmp("skid.stillA", 64'(a_out_data), 64'hA0);
    cmp("skid.ctrlA", 64'(a_out_ctrl), 64'h5A);
    step(1'b1, 32'hC0, 8'h5C, 1'b1, 1'b0);
    cmp("skid.B", 64'(a_out_data), 64'hB0);
    step(1'b1, 32'hC0, 8'h5C, 1'b1, 1'b0);
    cmp("skid.C", 64'(a_out_data), 64'hC0);
    step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
    cmp("skid.empty", 64'(a_out_valid), 64'd0);
    cmp("skid.stall", 64'(a_stall_cnt), 64'd2);

    // Flush from occupancy 2 with a valid input that must be discarded.
    step(1'b1, 32'hD0, 8'h71, 1'b0, 1'b0);
    step(1'b1, 32'hD1, 8'h72, 1'b0, 1'b0);
    cmp("flush.occ2", 64'(a_occupancy), 64'd2);
    step(1'b1, 32'hDD, 8'hFF, 1'b0, 1'b1);
    cmp("flush.valid", 64'(a_out_valid), 64'd0);
    cmp("flush.ctrl",  64'(a_out_ctrl),  64'd0);
    cmp("flush.occ",   64'(a_occupancy), 64'd0);
    cmp("flush.rdy",   64'(a_in_ready),  64'd1);
    cmp("flush.data",  64'(a_out_data),  64'hD0);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);
      cmp("flush.noD", 64'(a_out_valid), 64'd0);
    end

    // SKID=0: combinational ready, same-cycle replace.
    step(1'b1, 32'h55, 8'h3C, 1'b0, 1'b0);
    cmp("s0.valid", 64'(b_out_valid), 64'd1);
    cmp("s0.rdy0",  64'(b_in_ready),  64'd0);
    out_ready = 1'b1;
    #1;
    cmp("s0.rdy1", 64'(b_in_ready), 64'd1);
    step(1'b1, 32'h66, 8'h3D, 1'b1, 1'b0);
    cmp("s0.replace", 64'(b_out_data), 64'h66);
    cmp("s0.occ",     64'(b_occupancy), 64'd1);

    // 4-bit stall counter saturates.
    for (int k = 0; k < 20; k++) step(1'b0, 32'h0, 8'h0, 1'b0, 1'b0);
    cmp("sat.b_stall", 64'(b_stall_cnt), 64'd15);
    cmp("sat.b_data",  64'(b_out_data),  64'h66);
    step(1'b0, 32'h0, 8'h0, 1'b1, 1'b0);

    // Randomised traffic with varying backpressure, occasional flush and reset.
    for (int k = 0; k < 3000; k++) begin
      logic ordy;
      rst  = ($urandom_range(0, 299) != 0);
      ordy = ((k / 250) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step(1'($urandom_range(0, 1)), $urandom, 8'($urandom), ordy,
           ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
